// File: rtl/ysyx_22040632_booth_mul_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22040632_booth_mul_ctrl
//
// Iterative radix-4 Booth multiplier sequencer for the EXU mul path.
// One 64x64 (or 32x32 mulw) request is accepted at a time. Each BUSY cycle
// feeds one three-bit Booth window of the multiplier to the
// ysyx_22040632_booth partial-product generator and accumulates p + c
// into a 2*XLEN-bit sum. The product leaves through a valid/ready
// handshake. A flush aborts the operation and drops any pending result.
//
// Optional feature macro: YSYX_22040632_MUL_EARLY_TERM_EN
//   Defined   : a BUSY cycle whose remaining multiplier window is all-0 or
//               all-1 adds nothing and finishes the operation at that edge.
//   Undefined : fixed latency of XLEN/2+1 cycles (XLEN/4+1 for mulw).
//
// Ports
//   clk          in   1     rising-edge clock
//   rst_n        in   1     asynchronous active-low reset
//   mul_valid    in   1     request valid
//   mul_ready    out  1     request can be accepted (IDLE)
//   flush        in   1     abort in-flight op, drop pending result
//   mulw         in   1     32-bit op on operand[31:0]
//   mul_signed   in   2     [1] multiplicand signed, [0] multiplier signed
//   multiplicand in   XLEN  rs1
//   multiplier   in   XLEN  rs2
//   out_valid    out  1     result valid, held until out_ready
//   out_ready    in   1     consumer accepts result
//   result_hi    out  XLEN  product[2*XLEN-1:XLEN]; 0 for mulw
//   result_lo    out  XLEN  product[XLEN-1:0]; mulw: sext(product[31:0])
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// ysyx_22040632_booth
//
// Radix-4 Booth partial-product generator. Decodes one window
// {y[2k+1], y[2k], y[2k-1]} into 0, +-x or +-2x. Negative multiples are
// returned as the one's complement in p with c = 1, so the caller forms
// the two's complement for free inside its accumulating adder.
//
// Ports
//   in_x   in   W      multiplicand, already aligned to the current group
//   in_y   in   3      Booth window
//   index  in   CNT_W  extra group offset; x is shifted left by 2*index
//   p      out  W      partial product (inverted when negative)
//   c      out  1      carry-in completing the negation
// ---------------------------------------------------------------------------
module ysyx_22040632_booth #(
  parameter int W     = 128,
  parameter int CNT_W = 6
) (
  input  logic [W-1:0]     in_x,
  input  logic [2:0]       in_y,
  input  logic [CNT_W-1:0] index,
  output logic [W-1:0]     p,
  output logic             c
);

  logic [W-1:0] x_one;
  logic [W-1:0] x_two;

  assign x_one = in_x << {index, 1'b0};
  assign x_two = x_one << 1;

  // Booth recoding of the window into a signed multiple of x.
  always_comb begin
    p = '0;
    c = 1'b0;
    case (in_y)
      3'b001, 3'b010: p = x_one;
      3'b011:         p = x_two;
      3'b100: begin
        p = ~x_two;
        c = 1'b1;
      end
      3'b101, 3'b110: begin
        p = ~x_one;
        c = 1'b1;
      end
      default: begin
        p = '0;
        c = 1'b0;
      end
    endcase
  end

endmodule

module ysyx_22040632_booth_mul_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mul_valid,
  output logic            mul_ready,
  input  logic            flush,
  input  logic            mulw,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  localparam int PW = 2 * XLEN;
  // Multiplier register: two extension bits, XLEN data bits, y[-1].
  localparam int MW = XLEN + 3;
  localparam int HW = XLEN / 2;
  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(XLEN / 2);
  localparam logic [CNT_W-1:0] LAST_W    = CNT_W'(XLEN / 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [PW-1:0]   mcand_q;
  logic [MW-1:0]   mplier_q;
  logic [PW-1:0]   acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic            mulw_q;

  logic            accept;
  logic            last_group;
  logic            early_done;
  logic            finish;

  logic [XLEN-1:0] ext_x;
  logic [XLEN-1:0] ext_y;
  logic [PW-1:0]   mcand_init;
  logic [MW-1:0]   mplier_init;

  logic [PW-1:0]   booth_p;
  logic            booth_c;
  logic [PW-1:0]   acc_sum;
  logic [PW-1:0]   final_acc;
  logic [XLEN-1:0] res_hi_d;
  logic [XLEN-1:0] res_lo_d;

  // A flush in the same cycle as a request blocks the request.
  assign accept     = mul_valid & mul_ready & ~flush;
  assign last_group = (cnt_q == (mulw_q ? LAST_W : LAST_FULL));

`ifdef YSYX_22040632_MUL_EARLY_TERM_EN
  // Arithmetic right shifts keep the window sign-filled, so a uniform
  // window means every remaining group decodes to zero.
  assign early_done = (&mplier_q) | (~|mplier_q);
`else
  assign early_done = 1'b0;
`endif

  assign finish = last_group | early_done;

  // Operand extension. mulw first widens bits [31:0] to XLEN using the
  // operand's own signedness; the wide registers then extend the result.
  always_comb begin
    ext_x = mulw ? {{HW{mul_signed[1] & multiplicand[HW-1]}}, multiplicand[HW-1:0]}
                 : multiplicand;
    ext_y = mulw ? {{HW{mul_signed[0] & multiplier[HW-1]}}, multiplier[HW-1:0]}
                 : multiplier;
    mcand_init  = {{XLEN{mul_signed[1] & ext_x[XLEN-1]}}, ext_x};
    mplier_init = {{2{mul_signed[0] & ext_y[XLEN-1]}}, ext_y, 1'b0};
  end

  ysyx_22040632_booth #(
    .W     (PW),
    .CNT_W (CNT_W)
  ) u_booth (
    .in_x  (mcand_q),
    .in_y  (mplier_q[2:0]),
    .index ('0),
    .p     (booth_p),
    .c     (booth_c)
  );

  assign acc_sum = acc_q + booth_p + {{(PW-1){1'b0}}, booth_c};

  // The value captured into the result registers: an early-terminated op
  // adds nothing in its detect cycle, otherwise the last group is included.
  always_comb begin
    final_acc = early_done ? acc_q : acc_sum;
    if (mulw_q) begin
      res_hi_d = '0;
      res_lo_d = {{HW{final_acc[HW-1]}}, final_acc[HW-1:0]};
    end else begin
      res_hi_d = final_acc[PW-1:XLEN];
      res_lo_d = final_acc[XLEN-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept)    state_d = BUSY;
        BUSY:    if (finish)    state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    mul_ready = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    mul_ready = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        mul_ready = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: operand load on accept, one Booth group per BUSY cycle,
  // result capture on the BUSY->DONE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      mulw_q    <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
    end else if (accept) begin
      mcand_q  <= mcand_init;
      mplier_q <= mplier_init;
      acc_q    <= '0;
      cnt_q    <= '0;
      mulw_q   <= mulw;
    end else if ((state_q == BUSY) && !flush) begin
      if (!early_done) begin
        acc_q    <= acc_sum;
        mcand_q  <= mcand_q << 2;
        mplier_q <= {{2{mplier_q[MW-1]}}, mplier_q[MW-1:2]};
        cnt_q    <= cnt_q + 1'b1;
      end
      if (finish) begin
        result_hi <= res_hi_d;
        result_lo <= res_lo_d;
      end
    end
  end

endmodule
